// File: rtl/score_pkg.sv
// score_pkg: shared types, constants and helpers for the BCD score controller.
//   state_t   : sequencer states (IDLE, LOAD, ADD0..ADD3, COMMIT)
//   grant_t   : which event line owns the current addition
//   combo_t   : 2-bit ghost combo step
//   BCD_MAX   : saturation value for a 4-digit packed BCD score
package score_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, ADD0, ADD1, ADD2, ADD3, COMMIT} state_t;
    typedef enum logic [1:0] {G_PELLET, G_POWER, G_GHOST} grant_t;
    typedef logic [1:0] combo_t;
    localparam logic [15:0] BCD_MAX = 16'h9999;
    // Doubles a packed BCD value; a carry out of the top digit is dropped.
    function automatic logic [15:0] bcd_double(input logic [15:0] x);
        logic [15:0] r;
        logic [4:0] s;
        logic c;
        r = '0;
        c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s = {x[4*i +: 4], 1'b0} + {4'd0, c};
            c = s > 5'd9;
            s = c ? s + 5'd6 : s;
            r[4*i +: 4] = s[3:0];
        end
        return r;
    endfunction
    // Pending counter step: saturating increment on a pulse, decrement on grant.
    function automatic logic [1:0] pend_next(input logic [1:0] cnt, input logic inc, input logic dec);
        return (inc && !dec) ? ((cnt == 2'd3) ? 2'd3 : cnt + 2'd1) :
               (!inc && dec) ? cnt - 2'd1 : cnt;
    endfunction
endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: combinational single-digit BCD adder with decimal correction.
//   a, b : 4-bit BCD digits
//   ci   : carry in
//   sum  : corrected BCD digit
//   co   : decimal carry out
module bcd_digit_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] sum,
    output logic       co
);
    logic [4:0] raw;
    logic [4:0] fixed;
    always_comb begin
        raw   = {1'b0, a} + {1'b0, b} + {4'd0, ci};
        co    = raw > 5'd9;
        fixed = co ? raw + 5'd6 : raw;
        sum   = fixed[3:0];
    end
endmodule

// File: rtl/score_ctrl.sv
// score_ctrl: event-driven 4-digit BCD score accumulator with ghost combo and optional high score.
//   clk, rst              : clock, asynchronous active-high reset
//   clr                   : synchronous game restart (score, pending, combo, new_hi)
//   ev_pellet/power/ghost : one-cycle scoring event pulses
//   score                 : packed BCD score
//   busy                  : low only while the sequencer is idle
//   hiscore, new_hi       : best score and sticky "beaten this game" flag,
//                           present only when SCORE_HISCORE_EN is defined (else 0)
module score_ctrl
    import score_pkg::*;
#(
    parameter logic [15:0] PELLET_PTS = 16'h0010,
    parameter logic [15:0] POWER_PTS  = 16'h0050,
    parameter logic [15:0] GHOST_BASE = 16'h0200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        ev_pellet,
    input  logic        ev_power,
    input  logic        ev_ghost,
    output logic [15:0] score,
    output logic        busy,
    output logic [15:0] hiscore,
    output logic        new_hi
);
    localparam logic [15:0] GHOST_1 = bcd_double(GHOST_BASE);
    localparam logic [15:0] GHOST_2 = bcd_double(GHOST_1);
    localparam logic [15:0] GHOST_3 = bcd_double(GHOST_2);

    state_t      state;
    grant_t      gnt;
    grant_t      gnt_next;
    combo_t      combo;
    logic [1:0]  n_pel, n_pow, n_gho;
    logic [15:0] acc, op, ghost_pts;
    logic        cy;
    logic [1:0]  dig;
    logic [3:0]  da, db, ds;
    logic        dco;
    logic        any_pend;

    always_comb begin
        any_pend  = |{n_pel, n_pow, n_gho};
        gnt_next  = (n_gho != 2'd0) ? G_GHOST : (n_pow != 2'd0) ? G_POWER : G_PELLET;
        ghost_pts = (combo == 2'd0) ? GHOST_BASE : (combo == 2'd1) ? GHOST_1 :
                    (combo == 2'd2) ? GHOST_2 : GHOST_3;
        dig       = (state == ADD1) ? 2'd1 : (state == ADD2) ? 2'd2 : (state == ADD3) ? 2'd3 : 2'd0;
        da        = acc[{dig, 2'b00} +: 4];
        db        = op[{dig, 2'b00} +: 4];
        busy      = state != IDLE;
    end

    // One digit adder shared by all four ADD states; dig selects the nibble.
    bcd_digit_add u_add (
        .a   (da),
        .b   (db),
        .ci  (cy),
        .sum (ds),
        .co  (dco)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= G_PELLET;
            combo <= '0;
            n_pel <= '0;
            n_pow <= '0;
            n_gho <= '0;
            acc   <= '0;
            op    <= '0;
            cy    <= 1'b0;
            score <= '0;
        end else if (clr) begin
            state <= IDLE;
            combo <= '0;
            n_pel <= '0;
            n_pow <= '0;
            n_gho <= '0;
            cy    <= 1'b0;
            score <= '0;
        end else begin
            n_pel <= pend_next(n_pel, ev_pellet, state == LOAD && gnt == G_PELLET);
            n_pow <= pend_next(n_pow, ev_power,  state == LOAD && gnt == G_POWER);
            n_gho <= pend_next(n_gho, ev_ghost,  state == LOAD && gnt == G_GHOST);
            // A power pulse restarts the combo before any ghost in the same cycle is loaded.
            if (ev_power)
                combo <= '0;
            else if (state == COMMIT && gnt == G_GHOST && combo != 2'd3)
                combo <= combo + 2'd1;
            case (state)
                IDLE: if (any_pend) begin
                    state <= LOAD;
                    gnt   <= gnt_next;
                end
                LOAD: begin
                    acc   <= score;
                    op    <= (gnt == G_GHOST) ? ghost_pts : (gnt == G_POWER) ? POWER_PTS : PELLET_PTS;
                    cy    <= 1'b0;
                    state <= ADD0;
                end
                ADD0, ADD1, ADD2: begin
                    acc[{dig, 2'b00} +: 4] <= ds;
                    cy    <= dco;
                    state <= state_t'(state + 3'd1);
                end
                ADD3: begin
                    acc   <= dco ? BCD_MAX : {ds, acc[11:0]};
                    state <= COMMIT;
                end
                COMMIT: begin
                    score <= acc;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SCORE_HISCORE_EN
    logic [15:0] hi_q;
    logic        new_hi_q;
    // Packed BCD orders the same as binary, so a plain compare suffices.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q     <= '0;
            new_hi_q <= 1'b0;
        end else if (clr) begin
            new_hi_q <= 1'b0;
        end else if (state == COMMIT && acc > hi_q) begin
            hi_q     <= acc;
            new_hi_q <= 1'b1;
        end
    end
    assign hiscore = hi_q;
    assign new_hi  = new_hi_q;
`else
    assign hiscore = '0;
    assign new_hi  = 1'b0;
`endif
endmodule

// File: tb/tb_score_ctrl.sv
// tb_score_ctrl: directed self-checking bench for score_ctrl (default and carry-oriented parameter sets).
module tb_score_ctrl;
    import score_pkg::*;

`ifdef SCORE_HISCORE_EN
    localparam bit HI_EN = 1'b1;
`else
    localparam bit HI_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0, ev_pellet = 1'b0, ev_power = 1'b0, ev_ghost = 1'b0;
    logic b_clr = 1'b0, b_pellet = 1'b0, b_power = 1'b0, b_ghost = 1'b0;
    logic [15:0] score, hiscore, b_score, b_hiscore;
    logic busy, new_hi, b_busy, b_new_hi;
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    score_ctrl dut (
        .clk(clk), .rst(rst), .clr(clr),
        .ev_pellet(ev_pellet), .ev_power(ev_power), .ev_ghost(ev_ghost),
        .score(score), .busy(busy), .hiscore(hiscore), .new_hi(new_hi)
    );

    // Pellet 45 / power 50 / ghost 9990 make the carry and saturation cases reachable quickly.
    score_ctrl #(.PELLET_PTS(16'h0045), .POWER_PTS(16'h0050), .GHOST_BASE(16'h9990)) dut_b (
        .clk(clk), .rst(rst), .clr(b_clr),
        .ev_pellet(b_pellet), .ev_power(b_power), .ev_ghost(b_ghost),
        .score(b_score), .busy(b_busy), .hiscore(b_hiscore), .new_hi(b_new_hi)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        #1;
        chk("rst_score", score, 16'h0000);
        chk("rst_busy", {15'd0, busy}, 16'h0);
        chk("rst_hiscore", hiscore, 16'h0000);
        chk("rst_new_hi", {15'd0, new_hi}, 16'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single pellet: busy for exactly six cycles, then score 0010.
        ev_pellet = 1'b1;
        tick();
        ev_pellet = 1'b0;
        chk("pel_busy_pending", {15'd0, busy}, 16'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("pel_busy_high", {15'd0, busy}, 16'h1);
        end
        chk("pel_score_before_commit", score, 16'h0000);
        tick();
        chk("pel_busy_done", {15'd0, busy}, 16'h0);
        chk("pel_score", score, 16'h0010);

        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_score", score, 16'h0000);

        // Power then four ghosts ten cycles apart: combo 200/400/800/1600.
        ev_power = 1'b1;
        tick();
        ev_power = 1'b0;
        repeat (7) tick();
        chk("combo_power", score, 16'h0050);
        repeat (2) tick();
        ev_ghost = 1'b1;
        tick();
        ev_ghost = 1'b0;
        repeat (7) tick();
        chk("combo_g1", score, 16'h0250);
        repeat (2) tick();
        ev_ghost = 1'b1;
        tick();
        ev_ghost = 1'b0;
        repeat (7) tick();
        chk("combo_g2", score, 16'h0650);
        repeat (2) tick();
        ev_ghost = 1'b1;
        tick();
        ev_ghost = 1'b0;
        repeat (7) tick();
        chk("combo_g3", score, 16'h1450);
        repeat (2) tick();
        ev_ghost = 1'b1;
        tick();
        ev_ghost = 1'b0;
        repeat (7) tick();
        chk("combo_g4", score, 16'h3050);
        chk("combo_hiscore", hiscore, HI_EN ? 16'h3050 : 16'h0000);
        chk("combo_new_hi", {15'd0, new_hi}, {15'd0, HI_EN});

        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr2_new_hi", {15'd0, new_hi}, 16'h0);

        // All three lines in one cycle: ghost (200), then power (50), then pellet (10).
        ev_pellet = 1'b1;
        ev_power  = 1'b1;
        ev_ghost  = 1'b1;
        tick();
        ev_pellet = 1'b0;
        ev_power  = 1'b0;
        ev_ghost  = 1'b0;
        repeat (7) tick();
        chk("tri_ghost_first", score, 16'h0200);
        repeat (7) tick();
        chk("tri_power_second", score, 16'h0250);
        repeat (7) tick();
        chk("tri_pellet_last", score, 16'h0260);
        chk("tri_busy", {15'd0, busy}, 16'h0);
        chk("tri_new_hi", {15'd0, new_hi}, 16'h0);

        // clr while the pellet addition sits in ADD2.
        ev_pellet = 1'b1;
        tick();
        ev_pellet = 1'b0;
        repeat (4) tick();
        chk("mid_busy", {15'd0, busy}, 16'h1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("mid_clr_score", score, 16'h0000);
        chk("mid_clr_busy", {15'd0, busy}, 16'h0);
        chk("mid_clr_hiscore", hiscore, HI_EN ? 16'h3050 : 16'h0000);
        repeat (10) tick();
        chk("mid_clr_no_replay", score, 16'h0000);

        // Pellet counter saturates at 3 while power is being added: 50 + 3*10.
        ev_power = 1'b1;
        tick();
        ev_power = 1'b0;
        tick();
        ev_pellet = 1'b1;
        repeat (4) tick();
        ev_pellet = 1'b0;
        repeat (40) tick();
        chk("sat_pending", score, 16'h0080);

        // Digit carry and top-end saturation on the second instance.
        b_pellet = 1'b1;
        tick();
        b_pellet = 1'b0;
        repeat (9) tick();
        b_power = 1'b1;
        tick();
        b_power = 1'b0;
        repeat (9) tick();
        chk("b_0095", b_score, 16'h0095);
        b_power = 1'b1;
        tick();
        b_power = 1'b0;
        repeat (9) tick();
        chk("b_carry_0145", b_score, 16'h0145);
        b_clr = 1'b1;
        tick();
        b_clr = 1'b0;
        b_ghost = 1'b1;
        tick();
        b_ghost = 1'b0;
        repeat (9) tick();
        chk("b_9990", b_score, 16'h9990);
        b_power = 1'b1;
        tick();
        b_power = 1'b0;
        repeat (9) tick();
        chk("b_saturate", b_score, 16'h9999);
        chk("b_hiscore", b_hiscore, HI_EN ? 16'h9999 : 16'h0000);

        // Asynchronous reset in the middle of an addition.
        ev_pellet = 1'b1;
        tick();
        ev_pellet = 1'b0;
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_score", score, 16'h0000);
        chk("arst_busy", {15'd0, busy}, 16'h0);
        chk("arst_hiscore", hiscore, 16'h0000);
        chk("arst_b_score", b_score, 16'h0000);
        tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("arst_no_replay", score, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/score_ctrl.md
SCORE_CTRL -- requirements
Module: score_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  PELLET_PTS, 16'h0010, BCD points per pellet (10).
  POWER_PTS, 16'h0050, BCD points per power pellet (50).
  GHOST_BASE, 16'h0200, BCD points for the first ghost of a power period (200).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk, in, 1, sole clock; all state updates on its rising edge.
  rst, in, 1, asynchronous active-high reset.
  clr, in, 1, synchronous game restart; zeroes score and combo.
  ev_pellet, in, 1, one-cycle pulse: pellet eaten.
  ev_power, in, 1, one-cycle pulse: power pellet eaten; starts a new ghost combo.
  ev_ghost, in, 1, one-cycle pulse: ghost eaten.
  score, out, 16, 4-digit packed BCD score that feeds the seven-segment display driver.
  busy, out, 1, high while an addition is in progress.
  hiscore, out, 16, packed BCD best score (only when SCORE_HISCORE_EN is defined; otherwise tied to 0).
  new_hi, out, 1, sticky flag: score exceeded hiscore this game.

Function
REQ-003 Each ev_* pulse SHALL set its own pending bit; a pulse is never lost, even when busy=1.
REQ-004 A second pulse on a line whose pending bit is already set SHALL be counted by a 2-bit per-line pending counter that saturates at 3.
REQ-005 Arbitration SHALL be fixed priority, ghost > power > pellet, and SHALL be evaluated only in IDLE.
REQ-006 The FSM states SHALL be IDLE, LOAD, ADD0, ADD1, ADD2, ADD3, and COMMIT.
  IDLE -> LOAD when any pending bit is set.
  LOAD -> ADD0 -> ADD1 -> ADD2 -> ADD3 -> COMMIT -> IDLE.
REQ-007 LOAD SHALL latch the granted operand and decrement the granted pending count.
REQ-008 ADDn SHALL add BCD digit n of the operand, plus carry, to digit n of the working score; one digit is added per cycle.
REQ-009 A digit sum greater than 9 SHALL be corrected by adding 6 and SHALL generate a carry into the next digit.
REQ-010 A carry out of ADD3 SHALL saturate score at 16'h9999.
REQ-011 COMMIT SHALL update score; latency from grant to score update SHALL be 6 cycles.
REQ-012 busy SHALL be 0 only in IDLE.
REQ-013 The ghost operand SHALL be GHOST_BASE doubled per combo step (200, 400, 800, 1600).
  The combo step advances at each ghost COMMIT and saturates at 1600.
  ev_power resets the combo step to 0 at its pulse.
REQ-014 When ev_power and ev_ghost arrive in the same cycle, the combo reset SHALL take effect first.
REQ-015 Simultaneous pulses on different lines SHALL all be recorded and then serviced in priority order.
REQ-016 clr SHALL take priority over everything else.
  It zeroes score, the pending counters, the combo step and new_hi, and forces IDLE, including mid-addition.
  It does not clear hiscore.

Reset
REQ-017 Asserting rst SHALL immediately force the following, independent of clk.
  score=0, hiscore=0, new_hi=0, busy=0.
  All pending counters = 0, combo step = 0, state = IDLE.

Configuration
REQ-018 With SCORE_HISCORE_EN defined, a high-score register SHALL be compiled in.
  At each COMMIT where the new score is greater than hiscore, hiscore takes the new score and new_hi is set.
REQ-019 Without SCORE_HISCORE_EN, the high-score register SHALL be absent and hiscore and new_hi SHALL be constant 0.

Structure
REQ-020 Package score_pkg SHALL hold the following.
  The FSM state enum.
  The BCD saturation constant 16'h9999.
  The 2-bit combo step type.
REQ-021 One sub-module, bcd_digit_add, SHALL be used.
  It is combinational: 4-bit a, 4-bit b and carry-in produce a 4-bit sum and carry-out.
  score_ctrl instantiates it once and reuses it across ADD0 to ADD3.

Verification
REQ-022 The bench SHALL cover the following directed scenarios.
  A single ev_pellet from reset -> busy high for 6 cycles; then score=16'h0010.
  score=16'h0095 plus ev_power -> score=16'h0145, exercising the digit carry.
  ev_power, then four ev_ghost pulses 10 cycles apart -> score=16'h3050 (50+200+400+800+1600).
  ev_pellet, ev_power and ev_ghost in the same cycle -> all three serviced, ghost first; final score=16'h0260.
  score=16'h9990 plus ev_power -> score saturates at 16'h9999.
  clr asserted during ADD2 -> score=0, busy=0 next cycle; hiscore retained (with SCORE_HISCORE_EN).
